cdc_strobe_arbiter: RTL and testbench

//  Source-domain scheduler that shares one single-strobe CDC handshake between N local requesters.

---
 rtl/cdc_arb_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 32 +++
 rtl/cdc_strobe_arbiter.sv | 116 +++++++++++
 tb/tb_cdc_strobe_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_arb_pkg.sv
// Shared types and helpers for the CDC strobe arbiter.
// Holds the FSM state enum and the round-robin pick function.
package cdc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        BLANK,
        WAIT
    } state_t;

    localparam int BLANK_CYCLES = 1;

    // First set bit at or after ptr, wrapping within n; -1 if none.
    function automatic int rr_pick(
        input logic [15:0] req,
        input int          ptr,
        input int          n
    );
        int j;
        rr_pick = -1;
        for (int k = 15; k >= 0; k--) begin
            if (k < n) begin
                j = ptr + k;
                if (j >= n) j = j - n;
                if (req[j[3:0]]) rr_pick = j;
            end
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Returns the first requester at or after ptr as onehot and index.
module rr_arbiter
    import cdc_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [15:0] req_ext;
    int          win;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        win            = rr_pick(req_ext, int'(ptr), N);
        any            = (win >= 0);
        idx            = '0;
        onehot         = '0;
        if (any) begin
            idx    = IW'(win);
            onehot = N'(1) << idx;
        end
    end

endmodule

// File: rtl/cdc_strobe_arbiter.sv
// Round-robin scheduler sharing one CDC strobe handshake.
// Optional CDC_ARB_OVF_EN adds sticky overflow flags.
module cdc_strobe_arbiter
    import cdc_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = 3
) (
    input  logic                     source_clk,
    input  logic                     source_reset,
    input  logic [N_REQ-1:0]         req_strobe,
    output logic [N_REQ-1:0]         req_stall,
    output logic                     hs_strobe,
    output logic [$clog2(N_REQ)-1:0] hs_id,
    input  logic                     hs_stall,
    output logic                     busy
`ifdef CDC_ARB_OVF_EN
    ,
    output logic [N_REQ-1:0]         ovf_flag,
    input  logic                     ovf_clr
`endif
);

    localparam int IW = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    state_t state_q, state_d;

    logic [N_REQ-1:0][CNT_W-1:0] pend_q, pend_d;
    logic [N_REQ-1:0] stall_q, accept, dec, nz;
    logic [N_REQ-1:0] arb_oh, grant_oh_q;
    logic [IW-1:0]    ptr_q, arb_idx, id_q;
    logic             arb_any;
    logic [1:0]       blank_q;

    assign accept = req_strobe & ~stall_q;
    assign dec    = (state_q == GRANT) ? grant_oh_q : '0;

    always_comb begin
        pend_d = pend_q;
        nz     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            nz[i] = |pend_q[i];
            if (accept[i] && !dec[i])
                pend_d[i] = pend_q[i] + 1'b1;
            else if (dec[i] && !accept[i])
                pend_d[i] = pend_q[i] - 1'b1;
        end
    end

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_arb (
        .req    (nz),
        .ptr    (ptr_q),
        .onehot (arb_oh),
        .idx    (arb_idx),
        .any    (arb_any)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (arb_any && !hs_stall) state_d = GRANT;
            GRANT: state_d = BLANK;
            BLANK: if (blank_q == 2'(BLANK_CYCLES - 1)) state_d = WAIT;
            WAIT:  if (!hs_stall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge source_clk) begin
        if (source_reset) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            stall_q    <= '0;
            ptr_q      <= '0;
            id_q       <= '0;
            grant_oh_q <= '0;
            blank_q    <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            for (int i = 0; i < N_REQ; i++)
                stall_q[i] <= (pend_d[i] == PEND_MAX);
            // Winner is frozen at the grant decision so hs_id holds afterwards.
            if (state_q == IDLE && state_d == GRANT) begin
                id_q       <= arb_idx;
                grant_oh_q <= arb_oh;
            end
            if (state_q == GRANT) begin
                ptr_q   <= (id_q == IW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
                blank_q <= '0;
            end else if (state_q == BLANK) begin
                blank_q <= blank_q + 1'b1;
            end
        end
    end

    assign req_stall = stall_q;
    assign hs_strobe = (state_q == GRANT);
    assign hs_id     = id_q;
    assign busy      = (state_q != IDLE);

`ifdef CDC_ARB_OVF_EN
    // A drop in the same cycle as a clear must survive the clear.
    always_ff @(posedge source_clk) begin
        if (source_reset)
            ovf_flag <= '0;
        else
            ovf_flag <= (ovf_clr ? '0 : ovf_flag) | (req_strobe & stall_q);
    end
`endif

endmodule

// File: tb/tb_cdc_strobe_arbiter.sv
// Directed bench for cdc_strobe_arbiter (N_REQ=3, CNT_W=2).
// Includes a handshake model that stalls D cycles after each strobe.
module tb_cdc_strobe_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req_strobe = '0;
    logic [2:0] req_stall;
    logic       hs_strobe;
    logic [1:0] hs_id;
    logic       hs_stall;
    logic       busy;
`ifdef CDC_ARB_OVF_EN
    logic [2:0] ovf_flag;
    logic       ovf_clr = 1'b0;
`endif

    logic m_stall = 1'b0;
    logic force_stall = 1'b0;
    int   m_cnt = 0;
    int   d_fix = 3;
    bit   d_rand = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int gcnt[3] = '{default: 0};
    int gq[$];
    int since = 100;

    assign hs_stall = m_stall | force_stall;

    always #5 clk = ~clk;

    cdc_strobe_arbiter #(
        .N_REQ (3),
        .CNT_W (2)
    ) dut (
        .source_clk   (clk),
        .source_reset (rst),
        .req_strobe   (req_strobe),
        .req_stall    (req_stall),
        .hs_strobe    (hs_strobe),
        .hs_id        (hs_id),
        .hs_stall     (hs_stall),
        .busy         (busy)
`ifdef CDC_ARB_OVF_EN
        ,
        .ovf_flag     (ovf_flag),
        .ovf_clr      (ovf_clr)
`endif
    );

    always @(posedge clk) begin
        if (rst) begin
            m_stall <= 1'b0;
            m_cnt   <= 0;
        end else if (hs_strobe) begin
            m_stall <= 1'b1;
            m_cnt   <= d_rand ? int'($urandom_range(1, 6)) : d_fix;
        end else if (m_stall) begin
            if (m_cnt == 1) m_stall <= 1'b0;
            m_cnt <= m_cnt - 1;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst) begin
            since = 100;
        end else begin
            since++;
            if (hs_strobe) begin
                n_cmp++;
                if (hs_stall !== 1'b0) begin
                    n_bad++;
                    $display("FAIL strobe_in_stall: hs_stall=%b want 0", hs_stall);
                end
                n_cmp++;
                if (since < 4) begin
                    n_bad++;
                    $display("FAIL spacing: got %0d want >=4", since);
                end
                gq.push_back(int'(hs_id));
                gcnt[int'(hs_id)]++;
                since = 0;
            end
        end
    end

    task automatic wait_idle(input int limit, output bit ok);
        int quiet;
        quiet = 0;
        ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (!busy) quiet++;
            else quiet = 0;
            if (quiet >= 3) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (hs_strobe !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_strobe: got %b want 0", hs_strobe);
        end
        n_cmp++;
        if (hs_id !== 2'd0) begin
            n_bad++;
            $display("FAIL rst_id: got %0d want 0", hs_id);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_busy: got %b want 0", busy);
        end
        n_cmp++;
        if (req_stall !== 3'b000) begin
            n_bad++;
            $display("FAIL rst_stall: got %b want 000", req_stall);
        end
`ifdef CDC_ARB_OVF_EN
        n_cmp++;
        if (ovf_flag !== 3'b000) begin
            n_bad++;
            $display("FAIL rst_ovf: got %b want 000", ovf_flag);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_all_three();
        bit ok;
        gq.delete();
        @(negedge clk) req_strobe = 3'b111;
        @(negedge clk) req_strobe = 3'b000;
        wait_idle(80, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL three_timeout: busy=%b want idle", busy);
        end
        n_cmp++;
        if (gq.size() != 3) begin
            n_bad++;
            $display("FAIL three_count: got %0d want 3", gq.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (i < gq.size()) begin
                n_cmp++;
                if (gq[i] != i) begin
                    n_bad++;
                    $display("FAIL three_order%0d: got %0d want %0d", i, gq[i], i);
                end
            end
        end
    endtask

    task automatic test_single();
        bit ok;
        gq.delete();
        d_fix = 3;
        @(negedge clk) req_strobe = 3'b010;
        @(negedge clk) req_strobe = 3'b000;
        n_cmp++;
        if (hs_strobe !== 1'b0) begin
            n_bad++;
            $display("FAIL single_early: got %b want 0", hs_strobe);
        end
        @(negedge clk);
        n_cmp++;
        if (hs_strobe !== 1'b1) begin
            n_bad++;
            $display("FAIL single_latency: got %b want 1", hs_strobe);
        end
        n_cmp++;
        if (hs_id !== 2'd1) begin
            n_bad++;
            $display("FAIL single_id: got %0d want 1", hs_id);
        end
        wait_idle(40, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL single_timeout: busy=%b want idle", busy);
        end
        n_cmp++;
        if (gq.size() != 1) begin
            n_bad++;
            $display("FAIL single_count: got %0d want 1", gq.size());
        end
        n_cmp++;
        if (hs_id !== 2'd1) begin
            n_bad++;
            $display("FAIL single_id_hold: got %0d want 1", hs_id);
        end
    endtask

    task automatic test_saturate();
        bit ok;
        gq.delete();
        @(negedge clk) force_stall = 1'b1;
        repeat (5) @(negedge clk) req_strobe = 3'b100;
        @(negedge clk) req_strobe = 3'b000;
        n_cmp++;
        if (req_stall !== 3'b100) begin
            n_bad++;
            $display("FAIL sat_stall: got %b want 100", req_stall);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_blocked: busy=%b want 0", busy);
        end
`ifdef CDC_ARB_OVF_EN
        n_cmp++;
        if (ovf_flag !== 3'b100) begin
            n_bad++;
            $display("FAIL sat_ovf: got %b want 100", ovf_flag);
        end
`endif
        force_stall = 1'b0;
        wait_idle(80, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL sat_timeout: busy=%b want idle", busy);
        end
        n_cmp++;
        if (gq.size() != 3) begin
            n_bad++;
            $display("FAIL sat_count: got %0d want 3", gq.size());
        end
        foreach (gq[i]) begin
            n_cmp++;
            if (gq[i] != 2) begin
                n_bad++;
                $display("FAIL sat_id%0d: got %0d want 2", i, gq[i]);
            end
        end
        n_cmp++;
        if (req_stall !== 3'b000) begin
            n_bad++;
            $display("FAIL sat_unstall: got %b want 000", req_stall);
        end
`ifdef CDC_ARB_OVF_EN
        n_cmp++;
        if (ovf_flag !== 3'b100) begin
            n_bad++;
            $display("FAIL ovf_sticky: got %b want 100", ovf_flag);
        end
        ovf_clr = 1'b1;
        @(negedge clk) ovf_clr = 1'b0;
        n_cmp++;
        if (ovf_flag !== 3'b000) begin
            n_bad++;
            $display("FAIL ovf_clr: got %b want 000", ovf_flag);
        end
`endif
    endtask

    task automatic test_grant_collision();
        bit ok;
        gq.delete();
        @(negedge clk) req_strobe = 3'b001;
        @(negedge clk) req_strobe = 3'b000;
        @(negedge clk);
        n_cmp++;
        if (hs_strobe !== 1'b1 || hs_id !== 2'd0) begin
            n_bad++;
            $display("FAIL coll_grant: got %b/%0d want 1/0", hs_strobe, hs_id);
        end
        req_strobe = 3'b001;
        @(negedge clk) req_strobe = 3'b000;
        n_cmp++;
        if (req_stall !== 3'b000) begin
            n_bad++;
            $display("FAIL coll_stall: got %b want 000", req_stall);
        end
        wait_idle(80, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL coll_timeout: busy=%b want idle", busy);
        end
        n_cmp++;
        if (gq.size() != 2) begin
            n_bad++;
            $display("FAIL coll_count: got %0d want 2", gq.size());
        end
        foreach (gq[i]) begin
            n_cmp++;
            if (gq[i] != 0) begin
                n_bad++;
                $display("FAIL coll_id%0d: got %0d want 0", i, gq[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        gq.delete();
        d_fix = 10;
        @(negedge clk) req_strobe = 3'b110;
        @(negedge clk) req_strobe = 3'b110;
        @(negedge clk) req_strobe = 3'b000;
        n_cmp++;
        if (hs_strobe !== 1'b1 || hs_id !== 2'd1) begin
            n_bad++;
            $display("FAIL mid_grant: got %b/%0d want 1/1", hs_strobe, hs_id);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || hs_stall !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_wait: busy/stall %b%b want 11", busy, hs_stall);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (hs_strobe !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_rst: strobe/busy %b%b want 00", hs_strobe, busy);
        end
        n_cmp++;
        if (hs_id !== 2'd0) begin
            n_bad++;
            $display("FAIL mid_rst_id: got %0d want 0", hs_id);
        end
        n_cmp++;
        if (req_stall !== 3'b000) begin
            n_bad++;
            $display("FAIL mid_rst_stall: got %b want 000", req_stall);
        end
        rst = 1'b0;
        d_fix = 3;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (gq.size() != 1) begin
            n_bad++;
            $display("FAIL mid_lost: got %0d strobes want 1", gq.size());
        end
    endtask

    task automatic test_random();
        int  base[3];
        int  issued[3];
        logic [2:0] v;
        bit  ok;
        d_rand = 1'b1;
        for (int i = 0; i < 3; i++) begin
            base[i]   = gcnt[i];
            issued[i] = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            n_cmp++;
            if (req_stall !== 3'b000) begin
                n_bad++;
                $display("FAIL rnd_stall: got %b want 000 at %0d", req_stall, c);
            end
            v = '0;
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 3) == 0 &&
                    issued[i] - (gcnt[i] - base[i]) < 2) begin
                    v[i] = 1'b1;
                    issued[i]++;
                end
            end
            req_strobe = v;
        end
        @(negedge clk) req_strobe = 3'b000;
        wait_idle(300, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL rnd_timeout: busy=%b want idle", busy);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (gcnt[i] - base[i] != issued[i]) begin
                n_bad++;
                $display("FAIL rnd_id%0d: grants %0d want %0d",
                         i, gcnt[i] - base[i], issued[i]);
            end
        end
        d_rand = 1'b0;
    endtask

    initial begin
        test_reset();
        test_all_three();
        test_single();
        test_saturate();
        test_grant_collision();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: sim time %0t want finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
